// File: rtl/dcache_pkg.sv
// Shared dcache types and constants: request encodings, FSM states, queue entry layout.
// Length/op encodings and the I/O window base are defined once here for all dcache files.
package dcache_pkg;
  localparam int NICK_W = 4;
  localparam int LEN_W  = 2;

  localparam logic [LEN_W-1:0] LEN_ONE  = 2'd0;
  localparam logic [LEN_W-1:0] LEN_TWO  = 2'd1;
  localparam logic [LEN_W-1:0] LEN_FOUR = 2'd2;

  localparam logic LS_LOAD  = 1'b0;
  localparam logic LS_STORE = 1'b1;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int BUSY_LVL   = 3;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, XFER, RESP} state_t;

  // ls sits in the MSB so the queue can filter on it during a flush
  typedef struct packed {
    logic              ls;
    logic [NICK_W-1:0] nick;
    logic [LEN_W-1:0]  len;
    logic [31:0]       addr;
    logic [31:0]       dt;
  } req_t;

  localparam int REQ_W  = $bits(req_t);
  localparam int LS_BIT = REQ_W - 1;

  function automatic logic [2:0] len_bytes(input logic [LEN_W-1:0] len);
    case (len)
      LEN_ONE:  return 3'd1;
      LEN_TWO:  return 3'd2;
      LEN_FOUR: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*idx +: 8] = b;
    return r;
  endfunction
endpackage

// File: rtl/dcache_if.sv
// Requester, memory-port and I/O status signals of the dcache; slave = cache side.
// Global enable and flush travel with the bus so both sides see the same view.
interface dcache_if;
  import dcache_pkg::*;

  logic              rdy;
  logic              clr;
  logic              iSLB_en;
  logic              iSLB_ls;
  logic [NICK_W-1:0] iSLB_nick;
  logic [LEN_W-1:0]  iSLB_len;
  logic [31:0]       iSLB_addr;
  logic [31:0]       iSLB_dt;
  logic              oSLB_busy;
  logic              oSLB_en;
  logic [NICK_W-1:0] oSLB_nick;
  logic [31:0]       oSLB_dt;
  logic              oMEM_req;
  logic              iMEM_gnt;
  logic [31:0]       oMEM_a;
  logic              oMEM_wr;
  logic [7:0]        oMEM_dout;
  logic [7:0]        iMEM_din;
  logic              iIO_full;

  modport slave (
    input  rdy, clr, iSLB_en, iSLB_ls, iSLB_nick, iSLB_len, iSLB_addr, iSLB_dt,
           iMEM_gnt, iMEM_din, iIO_full,
    output oSLB_busy, oSLB_en, oSLB_nick, oSLB_dt, oMEM_req, oMEM_a, oMEM_wr, oMEM_dout
  );

  modport master (
    output rdy, clr, iSLB_en, iSLB_ls, iSLB_nick, iSLB_len, iSLB_addr, iSLB_dt,
           iMEM_gnt, iMEM_din, iIO_full,
    input  oSLB_busy, oSLB_en, oSLB_nick, oSLB_dt, oMEM_req, oMEM_a, oMEM_wr, oMEM_dout
  );
endinterface

// File: rtl/ls_fifo.sv
// Shift-style request queue, head always in slot 0; push visible to pop next cycle.
// Pushes while full are dropped; flt keeps only entries with KEEP_BIT set, in order.
module ls_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int KEEP_BIT = 0,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  input  logic             flt,
  output logic             full,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] flt_mem [DEPTH];
  logic [CW-1:0]    flt_cnt;
  logic [AW-1:0]    wr_pos;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[0];
  assign do_pop  = pop && (count != '0);
  assign do_push = push && !full;
  assign wr_pos  = AW'(do_pop ? count - CW'(1) : count);

  always_comb begin
    flt_mem = mem;
    flt_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && mem[i][KEEP_BIT]) begin
        flt_mem[flt_cnt[AW-1:0]] = mem[i];
        flt_cnt = flt_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (flt) begin
        mem   <= flt_mem;
        count <= flt_cnt;
      end else begin
        if (do_pop)
          for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i + 1];
        if (do_push) mem[wr_pos] <= din;
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end
endmodule

// File: rtl/dcache.sv
// Byte-serial load/store engine; load data returns len+1 cycles after the first address cycle.
// Requester must stop while oSLB_busy; memory side waits on grant and on I/O full for stores.
module dcache
  import dcache_pkg::*;
(
  input logic       clk,
  input logic       rst,
  dcache_if.slave   bus
);
  state_t           state;
  req_t             cur;
  req_t             head;
  req_t             in_req;
  logic [REQ_W-1:0] head_bits;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             pop;
  logic [2:0]       k;
  logic [2:0]       nbytes;
  logic [31:0]      ld_dat;
  logic             is_st;
  logic             io_blk;
  logic             ld_abort;

  assign in_req = '{ls: bus.iSLB_ls, nick: bus.iSLB_nick, len: bus.iSLB_len,
                    addr: bus.iSLB_addr, dt: bus.iSLB_dt};
  assign head   = head_bits;
  assign pop    = (state == IDLE) && !bus.clr && (fifo_cnt != '0);

  ls_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH), .KEEP_BIT(LS_BIT)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.rdy),
    .push  (bus.iSLB_en),
    .din   (in_req),
    .pop   (pop),
    .dout  (head_bits),
    .flt   (bus.clr),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  assign bus.oSLB_busy = fifo_full || (fifo_cnt >= CNT_W'(BUSY_LVL));

  assign is_st    = (cur.ls == LS_STORE);
  assign io_blk   = is_st && (cur.addr >= IO_BASE) && bus.iIO_full;
  assign ld_abort = bus.clr && !is_st;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur           <= '0;
      k             <= '0;
      nbytes        <= '0;
      ld_dat        <= '0;
      bus.oSLB_en   <= 1'b0;
      bus.oSLB_nick <= '0;
      bus.oSLB_dt   <= '0;
      bus.oMEM_req  <= 1'b0;
      bus.oMEM_a    <= '0;
      bus.oMEM_wr   <= 1'b0;
      bus.oMEM_dout <= '0;
    end else if (bus.rdy) begin
      bus.oSLB_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur    <= head;
            nbytes <= len_bytes(head.len);
            // unknown length encodings are consumed without touching memory
            if (len_bytes(head.len) != 3'd0) begin
              bus.oMEM_req <= 1'b1;
              state        <= WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          if (ld_abort) begin
            bus.oMEM_req <= 1'b0;
            state        <= IDLE;
          end else if (bus.iMEM_gnt && !io_blk) begin
            state         <= XFER;
            k             <= '0;
            ld_dat        <= '0;
            bus.oMEM_a    <= cur.addr;
            bus.oMEM_wr   <= is_st;
            bus.oMEM_dout <= is_st ? get_byte(cur.dt, 2'd0) : 8'h00;
          end
        end
        XFER: begin
          if (ld_abort) begin
            bus.oMEM_req  <= 1'b0;
            bus.oMEM_a    <= '0;
            bus.oMEM_wr   <= 1'b0;
            bus.oMEM_dout <= '0;
            state         <= IDLE;
          end else begin
            // read data trails its address by one cycle, so cycle k carries byte k-1
            if (!is_st && k != 3'd0)
              ld_dat <= put_byte(ld_dat, 2'(k - 3'd1), bus.iMEM_din);
            if (k == nbytes) begin
              bus.oSLB_en   <= 1'b1;
              bus.oSLB_nick <= cur.nick;
              bus.oSLB_dt   <= put_byte(ld_dat, 2'(k - 3'd1), bus.iMEM_din);
              state         <= RESP;
            end else if (k == nbytes - 3'd1) begin
              bus.oMEM_a    <= '0;
              bus.oMEM_wr   <= 1'b0;
              bus.oMEM_dout <= '0;
              if (is_st) begin
                bus.oMEM_req <= 1'b0;
                state        <= IDLE;
              end else begin
                k <= k + 3'd1;
              end
            end else begin
              k             <= k + 3'd1;
              bus.oMEM_a    <= cur.addr + 32'(k + 3'd1);
              bus.oMEM_dout <= is_st ? get_byte(cur.dt, 2'(k + 3'd1)) : 8'h00;
            end
          end
        end
        RESP: begin
          bus.oMEM_req <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: byte-wide memory model, delayable arbiter, response/write monitors.
module tb_dcache;
  import dcache_pkg::*;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   gnt_dly     = 0;
  int   gcnt        = 0;
  int   wr_cnt      = 0;
  int   wr_full_cnt = 0;
  int   req_cnt     = 0;
  int   n0, w0, r0, n;

  logic [7:0]  mem [0:262143];
  logic [3:0]  rsp_nick [$];
  logic [31:0] rsp_dt [$];

  dcache_if dif ();

  dcache u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign dif.iMEM_gnt = dif.oMEM_req && (gcnt >= gnt_dly);

  always @(posedge clk) begin
    if (!dif.oMEM_req) gcnt <= 0;
    else if (dif.rdy && gcnt < 1000) gcnt <= gcnt + 1;
  end

  // memory model: read data appears the cycle after its address
  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
    mem['h100] = 8'h11; mem['h101] = 8'h22; mem['h102] = 8'h33; mem['h103] = 8'h44;
    mem['h204] = 8'h5A;
    dif.iMEM_din = 8'h00;
    forever begin
      @(posedge clk);
      if (dif.rdy) begin
        dif.iMEM_din <= mem[dif.oMEM_a[17:0]];
        if (dif.oMEM_wr) mem[dif.oMEM_a[17:0]] <= dif.oMEM_dout;
      end
    end
  end

  always @(negedge clk) begin
    if (dif.rdy && !rst) begin
      if (dif.oSLB_en) begin
        rsp_nick.push_back(dif.oSLB_nick);
        rsp_dt.push_back(dif.oSLB_dt);
      end
      if (dif.oMEM_wr) begin
        wr_cnt++;
        if (dif.iIO_full) wr_full_cnt++;
      end
      if (dif.oMEM_req) req_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ls, input logic [3:0] nick, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] dt);
    dif.iSLB_en   = 1'b1;
    dif.iSLB_ls   = ls;
    dif.iSLB_nick = nick;
    dif.iSLB_len  = len;
    dif.iSLB_addr = addr;
    dif.iSLB_dt   = dt;
    tick(1);
    dif.iSLB_en   = 1'b0;
  endtask

  task automatic wait_addr(input logic [31:0] a, input int max, input string tag);
    int i = 0;
    while (dif.oMEM_a !== a && i < max) begin tick(1); i++; end
    chk(tag, dif.oMEM_a, a);
  endtask

  task automatic wait_rsp(input int cnt, input int max, input string tag);
    int i = 0;
    while (rsp_nick.size() < cnt && i < max) begin tick(1); i++; end
    chk(tag, rsp_nick.size(), cnt);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_slb_en"},   dif.oSLB_en,   0);
    chk({pfx, "_slb_nick"}, dif.oSLB_nick, 0);
    chk({pfx, "_slb_dt"},   dif.oSLB_dt,   0);
    chk({pfx, "_busy"},     dif.oSLB_busy, 0);
    chk({pfx, "_mem_req"},  dif.oMEM_req,  0);
    chk({pfx, "_mem_a"},    dif.oMEM_a,    0);
    chk({pfx, "_mem_wr"},   dif.oMEM_wr,   0);
    chk({pfx, "_mem_dout"}, dif.oMEM_dout, 0);
  endtask

  initial begin
    rst = 1'b1;
    dif.rdy = 1'b1; dif.clr = 1'b0; dif.iIO_full = 1'b0;
    dif.iSLB_en = 1'b0; dif.iSLB_ls = 1'b0; dif.iSLB_nick = '0;
    dif.iSLB_len = '0; dif.iSLB_addr = '0; dif.iSLB_dt = '0;
    tick(3);
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick(2);

    // word load, immediate grant
    n0 = rsp_nick.size();
    issue(LS_LOAD, 4'h5, LEN_FOUR, 32'h100, 32'h0);
    wait_addr(32'h100, 20, "t1_first_addr");
    n = 0;
    while (!dif.oSLB_en && n < 20) begin tick(1); n++; end
    chk("t1_latency", n, 5);
    chk("t1_nick", dif.oSLB_nick, 4'h5);
    chk("t1_dt", dif.oSLB_dt, 32'h4433_2211);
    tick(1);
    chk("t1_pulse_width", dif.oSLB_en, 0);
    tick(5);
    chk("t1_rsp_count", rsp_nick.size() - n0, 1);

    // half store
    n0 = rsp_nick.size(); w0 = wr_cnt;
    issue(LS_STORE, 4'h0, LEN_TWO, 32'h202, 32'hAABB_CCDD);
    tick(12);
    chk("t2_mem202", mem['h202], 8'hDD);
    chk("t2_mem203", mem['h203], 8'hCC);
    chk("t2_mem204", mem['h204], 8'h5A);
    chk("t2_writes", wr_cnt - w0, 2);
    chk("t2_no_rsp", rsp_nick.size() - n0, 0);

    // byte and half loads, zero-extended
    n0 = rsp_nick.size();
    issue(LS_LOAD, 4'h1, LEN_ONE, 32'h103, 32'h0);
    issue(LS_LOAD, 4'h2, LEN_TWO, 32'h101, 32'h0);
    wait_rsp(n0 + 2, 40, "t3_rsp_count");
    if (rsp_nick.size() >= n0 + 2) begin
      chk("t3_byte_nick", rsp_nick[n0], 4'h1);
      chk("t3_byte_dt", rsp_dt[n0], 32'h0000_0044);
      chk("t3_half_nick", rsp_nick[n0+1], 4'h2);
      chk("t3_half_dt", rsp_dt[n0+1], 32'h0000_3322);
    end

    // undefined length encoding is discarded
    tick(3);
    n0 = rsp_nick.size(); r0 = req_cnt;
    issue(LS_LOAD, 4'h3, 2'd3, 32'h100, 32'h0);
    tick(8);
    chk("t4_no_req", req_cnt - r0, 0);
    chk("t4_no_rsp", rsp_nick.size() - n0, 0);

    // four back-to-back requests, slow grant
    gnt_dly = 10;
    n0 = rsp_nick.size();
    issue(LS_LOAD, 4'h1, LEN_ONE, 32'h100, 32'h0);
    issue(LS_LOAD, 4'h2, LEN_ONE, 32'h101, 32'h0);
    issue(LS_LOAD, 4'h3, LEN_ONE, 32'h102, 32'h0);
    issue(LS_LOAD, 4'h4, LEN_ONE, 32'h103, 32'h0);
    chk("t5_busy", dif.oSLB_busy, 1);
    wait_rsp(n0 + 4, 200, "t5_rsp_count");
    if (rsp_nick.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t5_nick%0d", i), rsp_nick[n0+i], 32'(i + 1));
        chk($sformatf("t5_dt%0d", i), rsp_dt[n0+i], 32'h11 * (i + 1));
      end
    end
    chk("t5_busy_clear", dif.oSLB_busy, 0);

    // flush during an in-flight load with store and load queued behind it
    gnt_dly = 0;
    tick(4);
    n0 = rsp_nick.size(); w0 = wr_cnt;
    issue(LS_LOAD, 4'h7, LEN_FOUR, 32'h100, 32'h0);
    issue(LS_STORE, 4'h0, LEN_ONE, 32'h210, 32'h0000_00EE);
    issue(LS_LOAD, 4'h8, LEN_FOUR, 32'h100, 32'h0);
    wait_addr(32'h101, 20, "t6_load_xfer");
    dif.clr = 1'b1;
    dif.iSLB_en = 1'b1; dif.iSLB_ls = LS_STORE; dif.iSLB_len = LEN_ONE;
    dif.iSLB_addr = 32'h220; dif.iSLB_dt = 32'h99;
    tick(1);
    dif.clr = 1'b0; dif.iSLB_en = 1'b0;
    chk("t6_abort_req", dif.oMEM_req, 0);
    tick(15);
    chk("t6_no_rsp", rsp_nick.size() - n0, 0);
    chk("t6_store_done", mem['h210], 8'hEE);
    chk("t6_clr_pulse_ignored", mem['h220], 8'h00);
    chk("t6_writes", wr_cnt - w0, 1);

    // I/O store held off while the I/O buffer is full
    w0 = wr_cnt;
    dif.iIO_full = 1'b1;
    issue(LS_STORE, 4'h0, LEN_ONE, 32'h3_0000, 32'h77);
    tick(5);
    chk("t7_no_write_full", wr_cnt - w0, 0);
    chk("t7_req_waiting", dif.oMEM_req, 1);
    dif.iIO_full = 1'b0;
    tick(6);
    chk("t7_one_write", wr_cnt - w0, 1);
    chk("t7_mem", mem['h30000], 8'h77);
    chk("t7_write_while_full", wr_full_cnt, 0);

    // global enable low freezes a load mid-transfer
    n0 = rsp_nick.size();
    issue(LS_LOAD, 4'h9, LEN_FOUR, 32'h100, 32'h0);
    wait_addr(32'h101, 20, "t8_load_xfer");
    dif.rdy = 1'b0;
    tick(3);
    chk("t8_hold_addr", dif.oMEM_a, 32'h101);
    dif.rdy = 1'b1;
    wait_rsp(n0 + 1, 30, "t8_rsp_count");
    if (rsp_nick.size() >= n0 + 1) begin
      chk("t8_nick", rsp_nick[n0], 4'h9);
      chk("t8_dt", rsp_dt[n0], 32'h4433_2211);
    end

    // reset during the third byte of a word store, more work queued
    tick(2);
    issue(LS_STORE, 4'h0, LEN_FOUR, 32'h300, 32'hDDCC_BBAA);
    issue(LS_STORE, 4'h0, LEN_ONE, 32'h310, 32'h55);
    issue(LS_LOAD, 4'hA, LEN_FOUR, 32'h100, 32'h0);
    wait_addr(32'h302, 20, "t9_third_byte");
    rst = 1'b1;
    tick(1);
    chk_zero_outputs("t9_after_rst");
    rst = 1'b0;
    r0 = req_cnt;
    tick(20);
    chk("t9_queue_empty", req_cnt - r0, 0);
    chk("t9_mem300", mem['h300], 8'hAA);
    chk("t9_mem302", mem['h302], 8'hCC);
    chk("t9_mem303", mem['h303], 8'h00);
    chk("t9_mem310", mem['h310], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end
endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 rdy  input  1  global enable; when low, all state and outputs hold.
REQ-004 clr  input  1  pipeline flush from commit logic.
REQ-005 iSLB_en  input  1  request valid, one-cycle pulse per request.
REQ-006 iSLB_ls  input  1  `Load / `Store.
REQ-007 iSLB_nick  input  `NickBus  requester tag, returned with load data.
REQ-008 iSLB_len  input  `LenBus  access size: `One, `Two or `Four bytes.
REQ-009 iSLB_addr  input  32  byte address.
REQ-010 iSLB_dt  input  32  store data; ignored for loads.
REQ-011 oSLB_busy  output  1  request queue holds 3 or more entries; requester issues nothing while high.
REQ-012 oSLB_en  output  1  load result valid, one-cycle pulse.
REQ-013 oSLB_nick  output  `NickBus  tag of the returned load.
REQ-014 oSLB_dt  output  32  load data, zero-extended above len.
REQ-015 oMEM_req  output  1  memory-port request to the arbiter.
REQ-016 iMEM_gnt  input  1  memory-port grant; held by the arbiter while oMEM_req is high.
REQ-017 oMEM_a  output  32  memory byte address.
REQ-018 oMEM_wr  output  1  1 = write byte.
REQ-019 oMEM_dout  output  8  write byte.
REQ-020 iMEM_din  input  8  read byte, valid one cycle after its address cycle.
REQ-021 iIO_full  input  1  I/O buffer full.

Function
REQ-022 Requests enter a 4-entry FIFO in arrival order; a pulse arriving while the FIFO is full is dropped, and the bench flags it as a protocol error.
REQ-023 FSM states: IDLE, WAIT_GNT, XFER, RESP.
- IDLE: FIFO non-empty -> pop the head, raise oMEM_req, go to WAIT_GNT.
- WAIT_GNT: leave only when iMEM_gnt=1.
REQ-024 XFER uses a 3-bit byte counter k (0..len-1).
- In cycle k, oMEM_a = addr+k (32-bit wrap).
- Store: oMEM_wr=1, oMEM_dout = data[8k+7:8k] (little-endian).
- Load: oMEM_wr=0; byte k is sampled from iMEM_din in cycle k+1 into bits [8k+7:8k].
REQ-025 Store completion: after len write cycles, drop oMEM_req and return to IDLE; no oSLB_en pulse.
REQ-026 Load completion: after the last byte is sampled, enter RESP.
- RESP asserts oSLB_en for exactly one cycle with the entry's nick and data.
- It then drops oMEM_req and returns to IDLE.
REQ-027 Load latency: oSLB_en asserts len+1 cycles after the first address cycle.
REQ-028 Stores with addr >= 0x30000 stay in WAIT_GNT while iIO_full=1, even when granted.
REQ-029 Outside XFER: oMEM_wr=0, oMEM_a=0, oMEM_dout=0.
REQ-030 Simultaneous push and pop in one cycle are both honoured; FIFO count is unchanged.
REQ-031 clr handling:
- Remove all queued loads; queued stores keep their relative order.
- An in-flight load is aborted at once (oMEM_req low, no oSLB_en pulse).
- An in-flight store completes.
- An iSLB_en pulse in the clr cycle is ignored.
REQ-032 Encodings of `One, `Two and `Four are taken from config.v; len encodings other than these three produce no memory access, and the entry is discarded.

Reset
REQ-033 On rst: FIFO empty, FSM in IDLE, counter 0.
REQ-034 On rst, all outputs are 0: oSLB_en, oSLB_nick, oSLB_dt, oSLB_busy, oMEM_req, oMEM_a, oMEM_wr, oMEM_dout.
REQ-035 rst mid-transfer aborts immediately, including stores; a partially written word is not repaired.

Structure
REQ-036 `NickBus, `LenBus, `One/`Two/`Four, `Load/`Store and the 0x30000 I/O base live in the shared config.v.
REQ-037 The 4-entry request FIFO is one sub-module, ls_fifo, parameterised by width and depth, with push, pop, full, count and clr-filter ports.

Verification
REQ-038 Load word: mem[0x100..0x103] = 11 22 33 44, grant immediate -> oSLB_en once, 5 cycles after the first address cycle, dt = 0x44332211, nick echoed.
REQ-039 Store half: addr 0x202, dt 0xAABBCCDD -> writes DD to 0x202 and CC to 0x203, no oSLB_en pulse, mem[0x204] untouched.
REQ-040 Four back-to-back pulses, grant delayed 10 cycles -> oSLB_busy high after the 3rd pulse; requests are serviced in order.
REQ-041 Queue holds load, store, load; clr asserted during the first load -> no oSLB_en pulse; the store alone is executed.
REQ-042 Store byte to 0x30000 with iIO_full=1 for 6 cycles -> no oMEM_wr until iIO_full falls, then one write.
REQ-043 rst during the 3rd byte of a store word -> all outputs 0 on the next cycle; FIFO is empty.
